// File: rtl/rover_pkg.sv
// Shared rover definitions: job codes, decoder state encoding and the band classifier.
package rover_pkg;

  localparam logic [2:0] JOB_NONE = 3'd0;
  localparam logic [2:0] JOB_500  = 3'd1;
  localparam logic [2:0] JOB_1000 = 3'd2;
  localparam logic [2:0] JOB_2000 = 3'd3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COUNT    = 2'd1;
  localparam logic [1:0] ST_CLASSIFY = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  // Bands are tested in job order, so overlapping bands resolve to the lowest code.
  function automatic logic [2:0] classify_count(
    input int unsigned n,
    input int unsigned lo1, input int unsigned hi1,
    input int unsigned lo2, input int unsigned hi2,
    input int unsigned lo3, input int unsigned hi3
  );
    if (n >= lo1 && n <= hi1)      classify_count = JOB_500;
    else if (n >= lo2 && n <= hi2) classify_count = JOB_1000;
    else if (n >= lo3 && n <= hi3) classify_count = JOB_2000;
    else                           classify_count = JOB_NONE;
  endfunction

endpackage

// File: rtl/edge_sync_detect.sv
// Two-flop synchronizer for an asynchronous input plus a third flop for rising-edge detection.
module edge_sync_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], din};
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/freq_job_decoder.sv
// Counts beacon rising edges over a fixed gate window and maps the count to a job code,
// retrying a bounded number of times when the count falls outside every band.
module freq_job_decoder
  import rover_pkg::*;
#(
  parameter int GATE_CYCLES = 10_000_000,
  parameter int CNT_W       = 16,
  parameter int J1_LO       = 40,
  parameter int J1_HI       = 60,
  parameter int J2_LO       = 85,
  parameter int J2_HI       = 115,
  parameter int J3_LO       = 170,
  parameter int J3_HI       = 230,
  parameter int MAX_RETRY   = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             enable_count,
  input  logic             freq_in,
  output logic             done_count,
  output logic [2:0]       job,
  output logic [CNT_W-1:0] edge_count,
  output logic             busy
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);

  logic [1:0]       state;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [RW-1:0]    retry_cnt;
  logic             rise;
  logic [2:0]       match;

  edge_sync_detect u_sync (
    .clk   (CLK),
    .reset (reset),
    .din   (freq_in),
    .rise  (rise)
  );

  assign match = classify_count(32'(edge_cnt), J1_LO, J1_HI, J2_LO, J2_HI, J3_LO, J3_HI);
  assign busy  = (state == ST_COUNT) || (state == ST_CLASSIFY);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= ST_IDLE;
      done_count <= 1'b0;
      job        <= JOB_NONE;
      edge_count <= '0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      retry_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_count <= 1'b0;
          job        <= JOB_NONE;
          if (enable_count) begin
            gate_cnt  <= '0;
            edge_cnt  <= '0;
            retry_cnt <= '0;
            state     <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (!enable_count) begin
            state <= ST_IDLE;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
            if (rise && edge_cnt != CNT_MAX) edge_cnt <= edge_cnt + 1'b1;
            if (gate_cnt == GATE_LAST) state <= ST_CLASSIFY;
          end
        end
        ST_CLASSIFY: begin
          // A dropped request wins over classification so no job leaks out of an abort.
          if (!enable_count) begin
            state <= ST_IDLE;
          end else begin
            edge_count <= edge_cnt;
            if (match != JOB_NONE) begin
              job   <= match;
              state <= ST_DONE;
            end else if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              gate_cnt  <= '0;
              edge_cnt  <= '0;
              state     <= ST_COUNT;
            end else begin
              job   <= JOB_NONE;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (enable_count) begin
            done_count <= 1'b1;
          end else begin
            done_count <= 1'b0;
            job        <= JOB_NONE;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/freq_job_decoder.md
Name: freq_job_decoder

Overview:
- Responder to the rover state machine's frequency-count request.
- When `enable_count` is high, it measures the frequency of the washer beacon signal over a fixed gate window and classifies the result into a 3-bit job code.
- It then asserts `done_count` together with a stable `job` until the request drops.
- It sits between the beacon sensor input pin and the `enable_count`/`done_count`/`job` interface of the top-level state machine.

Parameters:
- GATE_CYCLES, 10_000_000: gate window length in CLK cycles (100 ms at 100 MHz).
- CNT_W, 16: edge counter width; the counter saturates at all-ones.
- J1_LO, 40 / J1_HI, 60: inclusive edge-count band for job 1 (500 Hz).
- J2_LO, 85 / J2_HI, 115: inclusive band for job 2 (1000 Hz).
- J3_LO, 170 / J3_HI, 230: inclusive band for job 3 (2000 Hz).
- MAX_RETRY, 2: extra measurements taken when no band matches.

Ports:
- CLK  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable_count  input  1  request from the state machine; level-held for the whole transaction.
- freq_in  input  1  asynchronous beacon signal.
- done_count  output  1  result valid; held until enable_count is low.
- job  output  3  job code; 0 means no valid frequency.
- edge_count  output  CNT_W  last completed window's edge count (debug/LED).
- busy  output  1  high in the COUNT and CLASSIFY states.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; done_count=0, job=0, edge_count=0, busy=0; sync flops, gate counter, edge counter and retry counter all 0.
- Input conditioning: freq_in passes through a 2-flop synchronizer plus a third flop for edge detection.
  - A rising edge on freq_in produces a 1-cycle pulse rise 3 cycles later.
  - Falling edges are ignored.
- IDLE:
  - done_count=0, job=0.
  - On enable_count=1 sampled: clear the gate, edge and retry counters, then go to COUNT.
- COUNT:
  - busy=1; gate counter increments every cycle.
  - Each rise pulse increments the edge counter, saturating at 2^CNT_W-1.
  - Exactly GATE_CYCLES cycles are spent in COUNT; rises in the cycle COUNT is entered are counted.
  - After the last cycle, go to CLASSIFY.
- CLASSIFY (1 cycle):
  - Register edge_count <= edge counter.
  - Compare the count against the bands in order J1, J2, J3; the first inclusive match wins.
  - If there is a match: job <= code, go to DONE.
  - If there is no match and retry_cnt < MAX_RETRY: increment retry_cnt, clear the gate and edge counters, go back to COUNT.
  - If there is no match and retries are exhausted: job <= 0, go to DONE.
- DONE:
  - done_count=1; job is stable.
  - Hold while enable_count=1.
  - On enable_count=0: go to IDLE; done_count and job become 0 on the next cycle.
- Latency: with enable_count sampled high at edge N, done_count is 1 from edge N+GATE_CYCLES+2 (no retry). Each retry adds GATE_CYCLES+1 cycles.
- Abort: enable_count=0 during COUNT or CLASSIFY returns the block to IDLE next cycle. No done_count is raised and job stays 0.
- Request persistence: enable_count held high across a DONE→IDLE transition cannot occur, since leaving DONE requires enable_count low. A new request needs a low→high sequence as seen from IDLE.
- Reset mid-operation: any state returns to the reset values on the next edge.
- Equal band boundaries: if bands overlap (mis-parameterized), the lowest job code wins.

Decomposition:
- Shared package rover_pkg:
  - Job code constants JOB_NONE=0, JOB_500=1, JOB_1000=2, JOB_2000=3; the state machine reuses these.
  - State encoding IDLE, COUNT, CLASSIFY, DONE as 2-bit localparams.
- One sub-module, edge_sync_detect: the 3-flop synchronizer with rising-edge pulse output. It is reused for the IPS detect input.

Test Plan (sim override GATE_CYCLES=1000, 10 ns clock):
- freq_in period 20 cycles, enable_count high at t0 → done_count=1 at cycle t0+1002, job=1, edge_count=50 (±1).
- freq_in period 10 cycles → job=2, edge_count≈100; drop enable_count → done_count=0 and job=0 one cycle later.
- freq_in held at 0 → two retries, done_count at t0+1002+2×1001, job=0, edge_count=0.
- Drop enable_count mid-window at cycle 500 → back to IDLE, done_count never asserts. Re-request with period 5 → job=3, edge_count≈200.
- reset asserted in DONE with job=2 → next cycle done_count=0, job=0, edge_count=0, busy=0.
- freq_in period 2 (500 edges/window) with CNT_W=8 → edge_count saturates at 255, no band match after retries → job=0.
